aes_enc_stream: RTL

//  Parametrised AES encryption engine. Supersedes the fixed AES-128 start/done top.

---
 rtl/aes_enc_stream.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/aes_enc_stream.sv
// Streaming AES encryptor: 128/256-bit keys, 1 or 2 rounds per clock, valid/ready on both sides.
// Round keys are expanded on the fly from a working window that advances in step with the rounds.
module aes_enc_stream #(
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned UNROLL   = 1,
  localparam int unsigned NR      = (KEY_BITS == 256) ? 14 : 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_plain,
  input  logic [KEY_BITS-1:0] in_key,
  input  logic                in_key_reuse,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_cipher,
  output logic                busy,
  output logic [NR-1:0]       round_done,
  output logic [15:0]         blk_count
);

  localparam int unsigned ITER = NR / UNROLL;
  localparam int unsigned CW   = 4;

  // One-hot so that busy/out_valid come straight off a state flop.
  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_ROUND = 3'b010;
  localparam logic [2:0] S_HOLD  = 3'b100;

  if (!(KEY_BITS == 128 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_enc_stream: KEY_BITS must be 128 or 256");
  end
  if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
    $error("aes_enc_stream: UNROLL must be 1 or 2");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Advance the key window by four words; the next round key ends up in the top 128 bits.
  function automatic logic [KEY_BITS-1:0] key_step(input logic [KEY_BITS-1:0] w,
                                                   input logic [4:0] step);
    logic [31:0]  t;
    logic [127:0] nw;
    if (KEY_BITS == 128)
      t = sub_word({w[23:0], w[31:24]}) ^ {rcon(4'(step)), 24'h0};
    else if (!step[0])
      t = sub_word({w[23:0], w[31:24]}) ^ {rcon(4'(step >> 1)), 24'h0};
    else
      t = sub_word(w[31:0]);
    nw[127:96] = w[KEY_BITS-1  -: 32] ^ t;
    nw[95:64]  = w[KEY_BITS-33 -: 32] ^ nw[127:96];
    nw[63:32]  = w[KEY_BITS-65 -: 32] ^ nw[95:64];
    nw[31:0]   = w[KEY_BITS-97 -: 32] ^ nw[63:32];
    return KEY_BITS'({w, nw});
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] sb, sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int b = 0; b < 16; b++) sb[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return (last ? sr : mc) ^ rk;
  endfunction

  logic [2:0]          state, state_next;
  logic [CW-1:0]       cnt;
  logic [127:0]        data, round_state;
  logic [KEY_BITS-1:0] ks, key_store, key_sel, round_key;
  logic                accept, last_iter;

  assign in_ready  = (state[0] & ~rst) | (state[2] & out_ready);
  assign busy      = state[1];
  assign out_valid = state[2];
  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == CW'(ITER - 1));
  assign key_sel   = in_key_reuse ? key_store : in_key;

  // UNROLL chained rounds per clock, each fed by the key window advanced one step.
  always_comb begin
    logic [127:0]        s;
    logic [KEY_BITS-1:0] k;
    s = data;
    k = ks;
    for (int u = 0; u < int'(UNROLL); u++) begin
      k = key_step(k, 5'(32'(cnt) * UNROLL + 32'(u)));
      s = aes_round(s, k[KEY_BITS-1 -: 128], (32'(cnt) * UNROLL + 32'(u) + 1) == NR);
    end
    round_state = s;
    round_key   = k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_ROUND;
      S_ROUND: if (last_iter) state_next = S_HOLD;
      S_HOLD:  if (out_ready) state_next = in_valid ? S_ROUND : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      ks         <= '0;
      key_store  <= '0;
      cnt        <= '0;
      round_done <= '0;
      out_cipher <= '0;
      blk_count  <= '0;
    end else begin
      if (accept) begin
        data       <= in_plain ^ key_sel[KEY_BITS-1 -: 128];
        ks         <= key_sel;
        key_store  <= key_sel;
        cnt        <= '0;
        round_done <= '0;
      end else if (busy) begin
        data <= round_state;
        ks   <= round_key;
        cnt  <= cnt + CW'(1);
        for (int i = 0; i < int'(NR); i++)
          if (32'(i) / UNROLL == 32'(cnt)) round_done[i] <= 1'b1;
        if (last_iter) out_cipher <= round_state;
      end
      if (out_valid & out_ready) blk_count <= blk_count + 16'd1;
    end
  end

endmodule
